// File: rtl/banked_ram_arbiter.sv
// Purpose: two-channel front end for banked_ram; stalls same-bank, same-op collisions with a round-robin winner.
// Latency: request to RAM 0 cycles (combinational); read response strobe 1 cycle after acceptance.
// Backpressure: the losing channel sees req_ready=0 for one cycle per conflict; responses cannot be stalled.
// Optional conflict counter: define BANKED_RAM_ARB_STATS_EN (otherwise conflict_cnt is tied to zero).
module banked_ram_arbiter #(
    parameter int TAG_W      = 2,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // channel A request / response
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_wr,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_data,
    // channel B request / response
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_wr,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_data,
    // RAM port A
    output logic                  ram_read_req_a,
    output logic [ADDR_WIDTH-1:0] ram_read_addr_a,
    output logic                  ram_write_req_a,
    output logic [ADDR_WIDTH-1:0] ram_write_addr_a,
    output logic [DATA_WIDTH-1:0] ram_write_data_a,
    input  logic [DATA_WIDTH-1:0] ram_read_data_a,
    // RAM port B
    output logic                  ram_read_req_b,
    output logic [ADDR_WIDTH-1:0] ram_read_addr_b,
    output logic                  ram_write_req_b,
    output logic [ADDR_WIDTH-1:0] ram_write_addr_b,
    output logic [DATA_WIDTH-1:0] ram_write_data_b,
    input  logic [DATA_WIDTH-1:0] ram_read_data_b,
    // statistics
    output logic [CNT_W-1:0]      conflict_cnt,
    input  logic                  stats_clear
);

    logic [TAG_W-1:0] w_tag_a;
    logic [TAG_W-1:0] w_tag_b;
    logic             w_conflict;
    logic             w_a_acc;
    logic             w_b_acc;
    logic             r_rr;          // 0: A favoured, 1: B favoured
    logic             r_a_rsp_vld;
    logic             r_b_rsp_vld;

    assign w_tag_a = a_req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_tag_b = b_req_addr[ADDR_WIDTH-1 -: TAG_W];

    // A read and a write never collide: they land on different RAM ports.
    assign w_conflict = a_req_valid && b_req_valid &&
                        (w_tag_a == w_tag_b) && (a_req_wr == b_req_wr);

    // Ready only reflects the arbitration loss, not the channel's own valid.
    assign a_req_ready = !(w_conflict && r_rr);
    assign b_req_ready = !(w_conflict && !r_rr);

    // Nothing reaches the RAM while held in reset.
    assign w_a_acc = reset_n && a_req_valid && a_req_ready;
    assign w_b_acc = reset_n && b_req_valid && b_req_ready;

    assign ram_read_req_a   = w_a_acc && !a_req_wr;
    assign ram_write_req_a  = w_a_acc && a_req_wr;
    assign ram_read_addr_a  = a_req_addr;
    assign ram_write_addr_a = a_req_addr;
    assign ram_write_data_a = a_req_wdata;

    assign ram_read_req_b   = w_b_acc && !b_req_wr;
    assign ram_write_req_b  = w_b_acc && b_req_wr;
    assign ram_read_addr_b  = b_req_addr;
    assign ram_write_addr_b = b_req_addr;
    assign ram_write_data_b = b_req_wdata;

    // RAM read data is already registered inside the RAM; only the strobe is delayed here.
    assign a_rsp_valid = r_a_rsp_vld;
    assign b_rsp_valid = r_b_rsp_vld;
    assign a_rsp_data  = ram_read_data_a;
    assign b_rsp_data  = ram_read_data_b;

    // Round-robin pointer: after a conflict the loser becomes favoured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr <= 1'b0;
        end else if (w_conflict) begin
            r_rr <= !r_rr;
        end
    end

    // Response strobes track the RAM's one-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_rsp_vld <= 1'b0;
            r_b_rsp_vld <= 1'b0;
        end else begin
            r_a_rsp_vld <= ram_read_req_a;
            r_b_rsp_vld <= ram_read_req_b;
        end
    end

`ifdef BANKED_RAM_ARB_STATS_EN
    logic [CNT_W-1:0] r_conflict_cnt;

    // Saturating conflict counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_conflict_cnt <= '0;
        end else if (stats_clear) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != {CNT_W{1'b1}})) begin
            r_conflict_cnt <= r_conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    logic w_unused_stats_clear;

    assign w_unused_stats_clear = stats_clear;
    assign conflict_cnt         = '0;
`endif

endmodule

// File: doc/banked_ram_arbiter.md
# banked_ram_arbiter

Two-requester arbiter in front of `banked_ram`. It drives the RAM's port A (LD/ST) and port B (RD/WR) and detects same-bank, same-operation collisions: the RAM resolves those silently in favour of port A, which would drop a port-B write or return wrong read data. On a collision it stalls the losing requester through a valid/ready handshake using a round-robin winner. It also produces a registered read-response strobe aligned with the RAM's one-cycle read latency.

## Interface
- `TAG_W`, 2, bank-select bits (upper bits of address); must match the RAM.
- `ADDR_WIDTH`, 13, full word address width.
- `DATA_WIDTH`, 16, word width.
- `CNT_W`, 16, conflict-counter width (only with stats enabled).
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `a_req_valid` / `b_req_valid`  in  1  request present on channel A / B.
- `a_req_ready` / `b_req_ready`  out  1  request accepted this cycle.
- `a_req_wr` / `b_req_wr`  in  1  1 = write, 0 = read.
- `a_req_addr` / `b_req_addr`  in  ADDR_WIDTH  word address, `{tag, local_addr}`.
- `a_req_wdata` / `b_req_wdata`  in  DATA_WIDTH  write data.
- `a_rsp_valid` / `b_rsp_valid`  out  1  read data valid.
- `a_rsp_data` / `b_rsp_data`  out  DATA_WIDTH  read data.
- `ram_read_req_a`, `ram_read_addr_a`, `ram_write_req_a`, `ram_write_addr_a`, `ram_write_data_a`  out  1 / ADDR_WIDTH / 1 / ADDR_WIDTH / DATA_WIDTH  RAM port A drive.
- `ram_read_req_b`, `ram_read_addr_b`, `ram_write_req_b`, `ram_write_addr_b`, `ram_write_data_b`  out  same widths  RAM port B drive.
- `ram_read_data_a` / `ram_read_data_b`  in  DATA_WIDTH  RAM read data.
- `conflict_cnt`  out  CNT_W  conflicts seen (stats build only).
- `stats_clear`  in  1  synchronous clear of `conflict_cnt` (stats build only).

## Operation
- Tag comparison: `tag_x = x_req_addr[ADDR_WIDTH-1 -: TAG_W]`.
- Conflict: both valids high, equal tags, equal `req_wr`.
- A read and a write to the same bank never conflict; they use separate RAM ports.
- Priority flop `rr` (0 = A favoured, 1 = B favoured). On a conflict the favoured channel wins.
- After a conflict cycle, `rr` points to the loser; non-conflict cycles leave `rr` unchanged. Worst-case stall is therefore 1 cycle per conflict.
- `a_req_ready = !(conflict && rr==1)`; `b_req_ready = !(conflict && rr==0)`.
  - Ready is combinational from the current inputs and independent of the channel's own valid gating.
- Accepted A requests drive RAM port A only; accepted B requests drive RAM port B only.
- Stalled requests drive neither `ram_*_req` for that channel.
- Addresses and data pass through unmodified.
- Read response: an accepted read in cycle t gives `x_rsp_valid` = 1 in cycle t+1.
  - `x_rsp_data = ram_read_data_x`, combinational passthrough.
- There is no response backpressure; the consumer must take data in cycle t+1.
- Same-cycle write and read to one address (different ports) return the old data. No forwarding.

## Timing
- Request-to-RAM: 0 cycles, combinational.
- Read request-to-response: 1 cycle.
- Back-to-back reads on the same channel give back-to-back responses.
- Reset values: `rr`=0, `a_rsp_valid`=`b_rsp_valid`=0, `conflict_cnt`=0. All `ram_*_req` are 0 while `reset_n`=0.
- Reset asserted mid-operation: a pending response is dropped immediately (async) and `rr` returns to 0.
- Integration must hold the RAM in reset (active-high, synchronous) for ≥1 clock around `reset_n` deassertion.
- Continuous conflicts: grants alternate A, B, A, B…; each channel sustains 50% throughput.

## Configuration
- `BANKED_RAM_ARB_STATS_EN` defined:
  - `conflict_cnt` increments once per conflict cycle and saturates at all-ones.
  - `stats_clear` zeroes it next cycle; clear has priority over increment.
- Not defined:
  - `conflict_cnt` is tied to 0 and `stats_clear` is ignored.
  - No counter flops are synthesized.

## Test plan
- No conflict: A reads 0x0005 and B writes 0x0005 in the same cycle.
  - Both readies = 1.
  - Next cycle `a_rsp_valid`=1 with the old value, not B's data.
- Write conflict after reset: A writes 0x0010←0x1111, B writes 0x0020←0x2222 (tag 0 both).
  - A granted, B stalled 1 cycle, then written.
  - Readback gives 0x1111 and 0x2222; `rr`=1 after the first cycle.
- Sustained read conflict: both channels read tag 3 for 8 cycles.
  - Grants alternate, starting with A.
  - 4 responses per channel, each exactly 1 cycle after its grant.
  - With stats, `conflict_cnt`=8.
- Different banks: A reads 0x0800, B reads 0x1000 every cycle for 16 cycles.
  - Both always ready, 16 responses each.
  - `conflict_cnt` unchanged.
- Reset mid-read: deassert `reset_n` in the cycle after a grant.
  - `a_rsp_valid` drops to 0 immediately; `rr`=0 after release.
- Stats saturation (`CNT_W`=4): 20 conflicts → `conflict_cnt`=15; `stats_clear` → 0 next cycle.
